// File: rtl/async_xfer_pkg.sv
// Types and constants shared by the transfer sequencer, the handshake engine
// and their benches.
package async_xfer_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } xfer_state_t;

   // Data width of the engine's native data path.
   localparam int XFER_DW = 4;

   typedef struct packed {
      logic               rw;
      logic [XFER_DW-1:0] data;
   } xfer_cmd_t;

   localparam logic RW_WRITE = 1'b0;
   localparam logic RW_READ  = 1'b1;

endpackage

// File: rtl/xfer_cmd_fifo.sv
// Small synchronous command FIFO with a combinational head output.
// Pointers wrap naturally because DEPTH is a power of two.
module xfer_cmd_fifo #(
   parameter int DEPTH = 4,
   parameter int W     = 5
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         push,
   input  logic                         pop,
   input  logic [W-1:0]                 wdata,
   output logic [W-1:0]                 rdata,
   output logic                         full,
   output logic                         empty,
   output logic [$clog2(DEPTH+1)-1:0]   level
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = $clog2(DEPTH+1);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wptr;
   logic [AW-1:0] rptr;
   logic          do_push;
   logic          do_pop;

   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   assign full  = (level == LW'(DEPTH));
   assign empty = (level == '0);
   assign rdata = mem[rptr];

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wptr] <= wdata;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wptr  <= '0;
         rptr  <= '0;
         level <= '0;
      end else begin
         if (do_push) begin
            wptr <= wptr + AW'(1);
         end
         if (do_pop) begin
            rptr <= rptr + AW'(1);
         end
         case ({do_push, do_pop})
            2'b10:   level <= level + LW'(1);
            2'b01:   level <= level - LW'(1);
            default: level <= level;
         endcase
      end
   end

endmodule

// File: rtl/async_xfer_sequencer.sv
// Queues write/read commands and feeds them one at a time to the async
// handshake engine, returning one response (data or timeout error) per command.
module async_xfer_sequencer
   import async_xfer_pkg::*;
#(
   parameter int DEPTH   = 4,
   parameter int DW      = 4,
   parameter int TIMEOUT = 16
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         cmd_valid,
   output logic                         cmd_ready,
   input  logic                         cmd_rw,
   input  logic [DW-1:0]                cmd_data,
   output logic                         link_start,
   output logic                         link_rw,
   output logic [DW-1:0]                link_wdata,
   input  logic                         link_done,
   input  logic [DW-1:0]                link_rdata,
   output logic                         rsp_valid,
   input  logic                         rsp_ready,
   output logic [DW-1:0]                rsp_data,
   output logic                         rsp_err,
   output logic                         busy,
   output logic [$clog2(DEPTH+1)-1:0]   level
);

   localparam int                CW   = $clog2(TIMEOUT);
   localparam logic [CW-1:0]     TMAX = CW'(TIMEOUT - 1);

   xfer_state_t   state;
   logic [CW-1:0] tcount;
   logic [DW:0]   head;
   logic          full;
   logic          empty;
   logic          push;
   logic          pop;

   // No bypass: a full FIFO refuses pushes even when a pop lands the same cycle.
   assign cmd_ready = rst && !full;
   assign push      = cmd_valid && cmd_ready;
   assign pop       = (state == BUSY) && (link_done || (tcount == TMAX));

   assign rsp_valid = (state == RESP);
   assign busy      = (state != IDLE);

   xfer_cmd_fifo #(
      .DEPTH (DEPTH),
      .W     (DW + 1)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .wdata ({cmd_rw, cmd_data}),
      .rdata (head),
      .full  (full),
      .empty (empty),
      .level (level)
   );

   // Passing through IDLE between commands guarantees the engine a low
   // cycle on link_start to re-arm; link_done takes priority over timeout.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         tcount     <= '0;
         link_start <= 1'b0;
         link_rw    <= 1'b0;
         link_wdata <= '0;
         rsp_data   <= '0;
         rsp_err    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (!empty) begin
                  state      <= BUSY;
                  link_start <= 1'b1;
                  link_rw    <= head[DW];
                  link_wdata <= head[DW-1:0];
                  tcount     <= '0;
               end
            end
            BUSY: begin
               if (link_done) begin
                  state      <= RESP;
                  link_start <= 1'b0;
                  rsp_err    <= 1'b0;
                  rsp_data   <= (link_rw == RW_READ) ? link_rdata : '0;
               end else if (tcount == TMAX) begin
                  state      <= RESP;
                  link_start <= 1'b0;
                  rsp_err    <= 1'b1;
                  rsp_data   <= '0;
               end else begin
                  tcount <= tcount + CW'(1);
               end
            end
            RESP: begin
               if (rsp_ready) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_async_xfer_sequencer.sv
// Directed bench for async_xfer_sequencer: a stub engine driven from tasks,
// with hand-computed expectations checked inline per scenario.
module tb_async_xfer_sequencer;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       cmd_valid = 1'b0;
   logic       cmd_ready;
   logic       cmd_rw = 1'b0;
   logic [3:0] cmd_data = '0;
   logic       link_start;
   logic       link_rw;
   logic [3:0] link_wdata;
   logic       link_done = 1'b0;
   logic [3:0] link_rdata = '0;
   logic       rsp_valid;
   logic       rsp_ready = 1'b0;
   logic [3:0] rsp_data;
   logic       rsp_err;
   logic       busy;
   logic [2:0] level;

   int tests_run = 0;
   int tests_failed = 0;

   async_xfer_sequencer #(.DEPTH(4), .DW(4), .TIMEOUT(16)) dut (
      .clk        (clk),
      .rst        (rst),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_rw     (cmd_rw),
      .cmd_data   (cmd_data),
      .link_start (link_start),
      .link_rw    (link_rw),
      .link_wdata (link_wdata),
      .link_done  (link_done),
      .link_rdata (link_rdata),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_data   (rsp_data),
      .rsp_err    (rsp_err),
      .busy       (busy),
      .level      (level)
   );

   always #5 clk = ~clk;

   task automatic push_cmd(input logic rw, input logic [3:0] d);
      @(negedge clk);
      cmd_valid = 1'b1;
      cmd_rw    = rw;
      cmd_data  = d;
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
   endtask

   task automatic pulse_done(input logic [3:0] d);
      @(negedge clk);
      link_done  = 1'b1;
      link_rdata = d;
      @(posedge clk);
      #1;
      link_done  = 1'b0;
      link_rdata = '0;
   endtask

   task automatic ack_rsp();
      @(negedge clk);
      rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      rsp_ready = 1'b0;
   endtask

   task automatic wait_start(input string name);
      int n;
      n = 0;
      while (!link_start && n < 8) begin
         @(posedge clk);
         #1;
         n++;
      end
      tests_run++;
      if (link_start !== 1'b1) begin
         tests_failed++;
         $display("[TB] FAIL %s wait_start: link_start=%b, required 1 within 8 cycles", name, link_start);
      end
   endtask

   task automatic test_reset();
      @(negedge clk);
      tests_run++;
      if ({link_start, link_rw, link_wdata, rsp_valid, rsp_data, rsp_err, busy, level, cmd_ready} !== 16'h0) begin
         tests_failed++;
         $display("[TB] FAIL reset_outputs: start=%b rw=%b wd=%h rv=%b rd=%h err=%b busy=%b lvl=%0d rdy=%b, required all 0",
                  link_start, link_rw, link_wdata, rsp_valid, rsp_data, rsp_err, busy, level, cmd_ready);
      end
      rst = 1'b1;
      #1;
      tests_run++;
      if (cmd_ready !== 1'b1) begin
         tests_failed++;
         $display("[TB] FAIL reset_release_ready: cmd_ready=%b, required 1", cmd_ready);
      end
   endtask

   task automatic test_single_write();
      push_cmd(1'b0, 4'd12);
      tests_run++;
      if (level !== 3'd1 || link_start !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL write_push: level=%0d start=%b, required 1/0", level, link_start);
      end
      @(posedge clk);
      #1;
      tests_run++;
      if (link_start !== 1'b1 || link_rw !== 1'b0 || link_wdata !== 4'd12 || busy !== 1'b1) begin
         tests_failed++;
         $display("[TB] FAIL write_start: start=%b rw=%b wd=%0d busy=%b, required 1/0/12/1", link_start, link_rw, link_wdata, busy);
      end
      repeat (4) @(posedge clk);
      #1;
      tests_run++;
      if (link_start !== 1'b1 || rsp_valid !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL write_hold: start=%b rv=%b, required 1/0", link_start, rsp_valid);
      end
      pulse_done(4'd9);
      tests_run++;
      if (rsp_valid !== 1'b1 || link_start !== 1'b0 || rsp_data !== 4'd0 || rsp_err !== 1'b0 || level !== 3'd0) begin
         tests_failed++;
         $display("[TB] FAIL write_rsp: rv=%b start=%b rd=%0d err=%b lvl=%0d, required 1/0/0/0/0",
                  rsp_valid, link_start, rsp_data, rsp_err, level);
      end
      ack_rsp();
      tests_run++;
      if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL write_ack: rv=%b busy=%b, required 0/0", rsp_valid, busy);
      end
      pulse_done(4'd5);
      tests_run++;
      if (rsp_valid !== 1'b0 || busy !== 1'b0 || link_start !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL idle_done_ignored: rv=%b busy=%b start=%b, required 0/0/0", rsp_valid, busy, link_start);
      end
   endtask

   task automatic test_single_read();
      push_cmd(1'b1, 4'd3);
      wait_start("read");
      tests_run++;
      if (link_rw !== 1'b1) begin
         tests_failed++;
         $display("[TB] FAIL read_rw: link_rw=%b, required 1", link_rw);
      end
      pulse_done(4'd13);
      tests_run++;
      if (rsp_valid !== 1'b1 || rsp_data !== 4'd13 || rsp_err !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL read_rsp: rv=%b rd=%0d err=%b, required 1/13/0", rsp_valid, rsp_data, rsp_err);
      end
      ack_rsp();
   endtask

   task automatic test_full_fifo();
      logic [3:0] exp_rd;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         cmd_valid = 1'b1;
         cmd_rw    = i[0];
         cmd_data  = 4'(i + 1);
         tests_run++;
         if (cmd_ready !== (i < 4)) begin
            tests_failed++;
            $display("[TB] FAIL full_ready[%0d]: cmd_ready=%b level=%0d, required %b", i, cmd_ready, level, (i < 4));
         end
         @(posedge clk);
         #1;
      end
      cmd_valid = 1'b0;
      tests_run++;
      if (level !== 3'd4) begin
         tests_failed++;
         $display("[TB] FAIL full_level: level=%0d, required 4", level);
      end
      for (int k = 0; k < 4; k++) begin
         tests_run++;
         if (link_start !== 1'b1 || link_wdata !== 4'(k + 1) || link_rw !== k[0]) begin
            tests_failed++;
            $display("[TB] FAIL order[%0d]: start=%b wd=%0d rw=%b, required 1/%0d/%b", k, link_start, link_wdata, link_rw, k + 1, k[0]);
         end
         pulse_done(4'(k + 7));
         exp_rd = k[0] ? 4'(k + 7) : 4'd0;
         tests_run++;
         if (rsp_valid !== 1'b1 || rsp_data !== exp_rd || rsp_err !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL order_rsp[%0d]: rv=%b rd=%0d err=%b, required 1/%0d/0", k, rsp_valid, rsp_data, rsp_err, exp_rd);
         end
         ack_rsp();
         tests_run++;
         if (link_start !== 1'b0 || busy !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL start_gap[%0d]: start=%b busy=%b, required 0/0", k, link_start, busy);
         end
         @(posedge clk);
         #1;
         tests_run++;
         if (link_start !== (k < 3)) begin
            tests_failed++;
            $display("[TB] FAIL next_start[%0d]: start=%b, required %b", k, link_start, (k < 3));
         end
      end
      tests_run++;
      if (level !== 3'd0) begin
         tests_failed++;
         $display("[TB] FAIL full_drain: level=%0d, required 0", level);
      end
   endtask

   task automatic test_timeout();
      int cnt;
      push_cmd(1'b0, 4'd6);
      push_cmd(1'b0, 4'd3);
      tests_run++;
      if (link_start !== 1'b1 || link_wdata !== 4'd6) begin
         tests_failed++;
         $display("[TB] FAIL timeout_start: start=%b wd=%0d, required 1/6", link_start, link_wdata);
      end
      cnt = 1;
      while (cnt < 40) begin
         @(posedge clk);
         #1;
         if (!link_start) break;
         cnt++;
      end
      tests_run++;
      if (cnt !== 16) begin
         tests_failed++;
         $display("[TB] FAIL timeout_len: start high %0d cycles, required 16", cnt);
      end
      tests_run++;
      if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_data !== 4'd0) begin
         tests_failed++;
         $display("[TB] FAIL timeout_rsp: rv=%b err=%b rd=%0d, required 1/1/0", rsp_valid, rsp_err, rsp_data);
      end
      ack_rsp();
      @(posedge clk);
      #1;
      tests_run++;
      if (link_start !== 1'b1 || link_wdata !== 4'd3) begin
         tests_failed++;
         $display("[TB] FAIL timeout_next: start=%b wd=%0d, required 1/3", link_start, link_wdata);
      end
      pulse_done(4'd0);
      tests_run++;
      if (rsp_err !== 1'b0 || rsp_valid !== 1'b1) begin
         tests_failed++;
         $display("[TB] FAIL timeout_next_rsp: err=%b rv=%b, required 0/1", rsp_err, rsp_valid);
      end
      ack_rsp();
   endtask

   task automatic test_collision();
      push_cmd(1'b1, 4'd0);
      @(posedge clk);
      #1;
      tests_run++;
      if (link_start !== 1'b1) begin
         tests_failed++;
         $display("[TB] FAIL collide_start: start=%b, required 1", link_start);
      end
      repeat (15) @(posedge clk);
      #1;
      tests_run++;
      if (link_start !== 1'b1 || rsp_valid !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL collide_hold: start=%b rv=%b, required 1/0", link_start, rsp_valid);
      end
      pulse_done(4'd10);
      tests_run++;
      if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_data !== 4'd10) begin
         tests_failed++;
         $display("[TB] FAIL collide_rsp: rv=%b err=%b rd=%0d, required 1/0/10", rsp_valid, rsp_err, rsp_data);
      end
      ack_rsp();
   endtask

   task automatic test_reset_mid();
      push_cmd(1'b0, 4'd1);
      push_cmd(1'b1, 4'd2);
      push_cmd(1'b0, 4'd4);
      tests_run++;
      if (link_start !== 1'b1 || level !== 3'd3) begin
         tests_failed++;
         $display("[TB] FAIL rstmid_setup: start=%b level=%0d, required 1/3", link_start, level);
      end
      @(negedge clk);
      #2;
      rst = 1'b0;
      #1;
      tests_run++;
      if (link_start !== 1'b0 || level !== 3'd0 || busy !== 1'b0 || rsp_valid !== 1'b0 || cmd_ready !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL rstmid_async: start=%b lvl=%0d busy=%b rv=%b rdy=%b, required 0/0/0/0/0",
                  link_start, level, busy, rsp_valid, cmd_ready);
      end
      @(negedge clk);
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      tests_run++;
      if (link_start !== 1'b0 || level !== 3'd0 || busy !== 1'b0 || rsp_valid !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL rstmid_after: start=%b lvl=%0d busy=%b rv=%b, required 0/0/0/0", link_start, level, busy, rsp_valid);
      end
   endtask

   initial begin
      test_reset();
      test_single_write();
      test_single_read();
      test_full_fifo();
      test_timeout();
      test_collision();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/async_xfer_sequencer.md
# async_xfer_sequencer

Command sequencer sitting directly upstream of the async master/slave handshake engine (`top`). It accepts write/read commands from the system side, buffers them in a small FIFO, and drives the engine's start/rw/data inputs one transfer at a time. It collects each transfer's completion and read data, and returns one response per command, with a timeout error when the engine never completes.

## Interface
- `DEPTH`, 4: command FIFO entries (power of two, ≥2)
- `DW`, 4: data width, matches engine data path
- `TIMEOUT`, 16: max BUSY cycles before abort (≥2)

- `clk`  in  1  system clock
- `rst`  in  1  reset; **one clock; reset is asynchronous and active-low**
- `cmd_valid`  in  1  command offered
- `cmd_ready`  out  1  FIFO can accept
- `cmd_rw`  in  1  0 = write to slave, 1 = read from slave
- `cmd_data`  in  DW  write data (ignored for reads)
- `link_start`  out  1  level start to engine
- `link_rw`  out  1  rw to engine
- `link_wdata`  out  DW  write data to engine
- `link_done`  in  1  engine transfer complete, single-cycle pulse
- `link_rdata`  in  DW  engine received data, valid with `link_done`
- `rsp_valid`  out  1  response available
- `rsp_ready`  in  1  response consumed
- `rsp_data`  out  DW  read data; 0 for writes and errors
- `rsp_err`  out  1  timeout abort
- `busy`  out  1  state ≠ IDLE
- `level`  out  $clog2(DEPTH+1)  FIFO occupancy

## Operation
- **Push rule:** push on `cmd_valid && cmd_ready`.
- **`cmd_ready`:** `cmd_ready = (level < DEPTH)` and is forced 0 while `rst` is low. There is no bypass when full: a push is refused even if a pop happens in the same cycle.
- **Pop rule:** pop only at the BUSY→RESP transition. Push and pop in the same cycle leave `level` unchanged.
- **FSM states:** IDLE, BUSY, RESP.
  - IDLE → BUSY when `level > 0`. Register the head entry into `link_rw`/`link_wdata`, set `link_start` = 1 and the timeout counter = 0.
  - BUSY → RESP on `link_done`. Clear `link_start` and pop. Set `rsp_err` = 0 and `rsp_data` = `link_rdata` if rw = 1, else 0.
  - BUSY → RESP when counter = TIMEOUT−1 with no `link_done`. Clear `link_start` and pop. Set `rsp_err` = 1 and `rsp_data` = 0.
  - BUSY otherwise: counter +1; `link_start`/`link_rw`/`link_wdata` stay stable.
  - RESP → IDLE on `rsp_ready`; `rsp_valid` is high throughout RESP.
- **Event priority:** `link_done` wins over timeout in the same cycle.
- **Out-of-state `link_done`:** ignored in IDLE and RESP.
- **`link_start` low gap:** IDLE is always visited between commands, so `link_start` is low ≥1 cycle between transfers. The engine needs this gap to re-arm.
- **Reset:** asynchronous reset mid-transfer drops `link_start` immediately, empties the FIFO and discards any pending response.
- **Reset values:** every output is 0, state = IDLE, FIFO pointers = 0.

## Timing
- **Command to start:** push at edge N into an empty FIFO → `link_start` = 1 after edge N+1.
- **Done to response:** `link_done` sampled at edge M → `rsp_valid` = 1 and `link_start` = 0 after edge M.
- **Response to next start:** `rsp_ready` at edge K → IDLE after K. The next `link_start` is high after K+1 at the earliest.
- **Timeout latency:** `link_start` is high for exactly TIMEOUT cycles before `rsp_err` is raised.
- **Back-to-back overhead:** minimum 3 cycles per command beyond engine latency (IDLE, BUSY-done edge, RESP).
- **FIFO wrap:** pointers are $clog2(DEPTH) bits and wrap naturally. `level` ranges 0..DEPTH.

## Structure
- **Shared package `async_xfer_pkg`:**
  - state enum (IDLE, BUSY, RESP)
  - command struct {rw, data[DW-1:0]}
  - constants RW_WRITE = 0, RW_READ = 1
  - shared with the engine and its bench
- **Sub-module `xfer_cmd_fifo`:**
  - synchronous FIFO, DEPTH × (DW+1)
  - ports: push, pop, wdata, rdata (head, combinational), full, empty, level
  - same `clk`/`rst`
- **Top level:** FSM, timeout counter and response register live in `async_xfer_sequencer`.

## Test plan
- **Single write:** reset, push write 4'd12 → `link_start` = 1, `link_rw` = 0, `link_wdata` = 12. Stub `link_done` after 5 cycles → `rsp_valid` = 1, `rsp_data` = 0, `rsp_err` = 0.
- **Single read:** push read, stub returns `link_rdata` = 4'd13 with `link_done` → `rsp_data` = 13, `rsp_err` = 0.
- **Full FIFO:** hold `rsp_ready` = 0 and push 5 commands → first 4 accepted, `cmd_ready` = 0 at `level` = 4. Commands issue in order with a ≥1-cycle `link_start` gap between them.
- **Timeout:** never assert `link_done` → `link_start` high exactly 16 cycles, then `rsp_err` = 1, `rsp_data` = 0. The next queued command then issues.
- **Done/timeout collision:** `link_done` on the 16th BUSY cycle → `rsp_err` = 0 and the data is captured.
- **Reset mid-transfer:** assert `rst` = 0 during BUSY with 3 entries queued → `link_start` drops asynchronously. After release: `level` = 0, `rsp_valid` = 0, state IDLE.
